// File: rtl/centroid_update_sequencer_pkg.sv
// Shared types and constants for the centroid update sequencer.
// Holds the FSM state encoding and the centroid geometry.
package centroid_update_sequencer_pkg;

    localparam int CENTROID_NUM   = 8;
    localparam int CORD_NUM       = 7;
    localparam int DATA_WIDTH_DEF = 91;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_WAIT_RES,
        S_DONE
    } state_e;

endpackage

// File: rtl/centroid_update_sequencer_reg_file.sv
// Eight-entry centroid register file with an init port and a
// write-back port; the init port wins on an address collision.
module centroid_update_sequencer_reg_file
    import centroid_update_sequencer_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_we,
    input  logic [2:0]           init_addr,
    input  logic [dataWidth-1:0] init_data,
    input  logic                 wb_we,
    input  logic [2:0]           wb_addr,
    input  logic [dataWidth-1:0] wb_data,
    output logic [dataWidth-1:0] regs [CENTROID_NUM]
);

    logic [dataWidth-1:0] mem_q [CENTROID_NUM];
    logic [dataWidth-1:0] mem_d [CENTROID_NUM];

    always_comb begin
        mem_d = mem_q;
        if (wb_we) begin
            mem_d[wb_addr] = wb_data;
        end
        if (init_we) begin
            mem_d[init_addr] = init_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CENTROID_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign regs = mem_q;

endmodule

// File: rtl/centroid_update_sequencer.sv
// Sequences one centroid update round: clear the checker, stream
// eight means into it, write results back, then decide convergence.
module centroid_update_sequencer
    import centroid_update_sequencer_pkg::*;
#(
    parameter int dataWidth  = DATA_WIDTH_DEF,
    parameter int iter_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [iter_width-1:0] max_iter,
    input  logic                  init_we,
    input  logic [2:0]            init_addr,
    input  logic [dataWidth-1:0]  init_data,
    input  logic                  mean_valid,
    input  logic [dataWidth-1:0]  mean_data,
    input  logic                  mean_div0,
    output logic                  mean_ready,
    output logic [dataWidth-1:0]  new_centroid_in,
    output logic [2:0]            cent_num,
    output logic                  divide_by_0,
    output logic                  convergence_reg_en,
    output logic                  convergence_regs_reset_n,
    input  logic                  has_converged,
    input  logic                  converge_res_available,
    input  logic [dataWidth-1:0]  new_centroid_out,
    output logic [dataWidth-1:0]  old_centroid_reg_1,
    output logic [dataWidth-1:0]  old_centroid_reg_2,
    output logic [dataWidth-1:0]  old_centroid_reg_3,
    output logic [dataWidth-1:0]  old_centroid_reg_4,
    output logic [dataWidth-1:0]  old_centroid_reg_5,
    output logic [dataWidth-1:0]  old_centroid_reg_6,
    output logic [dataWidth-1:0]  old_centroid_reg_7,
    output logic [dataWidth-1:0]  old_centroid_reg_8,
    output logic                  round_done,
    output logic                  converged,
    output logic                  algo_done,
    output logic [iter_width-1:0] iter_count
);

    state_e                state_q, state_d;
    logic [2:0]            k_q, k_d;
    logic                  mean_ready_q, mean_ready_d;
    logic [dataWidth-1:0]  cent_in_q, cent_in_d;
    logic [2:0]            cent_num_q, cent_num_d;
    logic                  div0_q, div0_d;
    logic                  en_q, en_d;
    logic                  crst_n_q, crst_n_d;
    logic                  wb_en_q, wb_en_d;
    logic [2:0]            wb_idx_q, wb_idx_d;
    logic                  lat_seen_q, lat_seen_d;
    logic                  lat_val_q, lat_val_d;
    logic                  round_done_q, round_done_d;
    logic                  converged_q, converged_d;
    logic                  algo_done_q, algo_done_d;
    logic [iter_width-1:0] iter_q, iter_d;

    logic                  accept;
    logic                  init_ok;
    logic                  res_conv;
    logic [iter_width-1:0] iter_inc;
    logic [iter_width-1:0] max_eff;
    logic [dataWidth-1:0]  regs [CENTROID_NUM];

    assign accept   = mean_valid && mean_ready_q;
    assign init_ok  = init_we && (state_q == S_IDLE || state_q == S_DONE);
    assign iter_inc = (&iter_q) ? iter_q : iter_q + iter_width'(1);
    assign max_eff  = (max_iter == '0) ? iter_width'(1) : max_iter;
    // The result may arrive on the very edge we exit, before latching.
    assign res_conv = lat_seen_q ? lat_val_q : has_converged;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        cent_in_d    = cent_in_q;
        cent_num_d   = cent_num_q;
        div0_d       = div0_q;
        en_d         = 1'b0;
        wb_en_d      = en_q;
        wb_idx_d     = cent_num_q;
        lat_seen_d   = lat_seen_q;
        lat_val_d    = lat_val_q;
        round_done_d = 1'b0;
        converged_d  = converged_q;
        iter_d       = iter_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_CLR;
                    k_d        = '0;
                    cent_num_d = '0;
                    lat_seen_d = 1'b0;
                    if (state_q == S_DONE) begin
                        iter_d      = '0;
                        converged_d = 1'b0;
                    end
                end
            end
            S_CLR: state_d = S_FEED;
            S_FEED: begin
                if (accept) begin
                    cent_in_d  = mean_data;
                    div0_d     = mean_div0;
                    cent_num_d = k_q;
                    en_d       = 1'b1;
                    k_d        = k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        state_d = S_WAIT_RES;
                    end
                end
            end
            S_WAIT_RES: begin
                if (converge_res_available && !lat_seen_q) begin
                    lat_seen_d = 1'b1;
                    lat_val_d  = has_converged;
                end
                if (converge_res_available && !wb_en_q) begin
                    iter_d       = iter_inc;
                    round_done_d = 1'b1;
                    if (res_conv) begin
                        state_d     = S_DONE;
                        converged_d = 1'b1;
                    end else if (iter_inc >= max_eff) begin
                        state_d     = S_DONE;
                        converged_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        mean_ready_d = (state_d == S_FEED);
        algo_done_d  = (state_d == S_DONE);
        crst_n_d     = (state_d != S_CLR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            mean_ready_q <= 1'b0;
            cent_in_q    <= '0;
            cent_num_q   <= '0;
            div0_q       <= 1'b0;
            en_q         <= 1'b0;
            crst_n_q     <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_idx_q     <= '0;
            lat_seen_q   <= 1'b0;
            lat_val_q    <= 1'b0;
            round_done_q <= 1'b0;
            converged_q  <= 1'b0;
            algo_done_q  <= 1'b0;
            iter_q       <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            mean_ready_q <= mean_ready_d;
            cent_in_q    <= cent_in_d;
            cent_num_q   <= cent_num_d;
            div0_q       <= div0_d;
            en_q         <= en_d;
            crst_n_q     <= crst_n_d;
            wb_en_q      <= wb_en_d;
            wb_idx_q     <= wb_idx_d;
            lat_seen_q   <= lat_seen_d;
            lat_val_q    <= lat_val_d;
            round_done_q <= round_done_d;
            converged_q  <= converged_d;
            algo_done_q  <= algo_done_d;
            iter_q       <= iter_d;
        end
    end

    centroid_update_sequencer_reg_file #(
        .dataWidth (dataWidth)
    ) u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_we   (init_ok),
        .init_addr (init_addr),
        .init_data (init_data),
        .wb_we     (wb_en_q),
        .wb_addr   (wb_idx_q),
        .wb_data   (new_centroid_out),
        .regs      (regs)
    );

    assign mean_ready               = mean_ready_q;
    assign new_centroid_in          = cent_in_q;
    assign cent_num                 = cent_num_q;
    assign divide_by_0              = div0_q;
    assign convergence_reg_en       = en_q;
    assign convergence_regs_reset_n = crst_n_q;
    assign round_done               = round_done_q;
    assign converged                = converged_q;
    assign algo_done                = algo_done_q;
    assign iter_count               = iter_q;
    assign old_centroid_reg_1       = regs[0];
    assign old_centroid_reg_2       = regs[1];
    assign old_centroid_reg_3       = regs[2];
    assign old_centroid_reg_4       = regs[3];
    assign old_centroid_reg_5       = regs[4];
    assign old_centroid_reg_6       = regs[5];
    assign old_centroid_reg_7       = regs[6];
    assign old_centroid_reg_8       = regs[7];

endmodule

// File: tb/tb_centroid_update_sequencer.sv
// Self-checking bench: scenario table, randomized rounds against a
// round-level model, and a reset-during-wait sequence.
module tb_centroid_update_sequencer;
    import centroid_update_sequencer_pkg::*;

    localparam int DW = 91;
    localparam int CW = DW / CORD_NUM;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    max_iter;
    logic          init_we;
    logic [2:0]    init_addr;
    logic [DW-1:0] init_data;
    logic          mean_valid;
    logic [DW-1:0] mean_data;
    logic          mean_div0;
    logic          mean_ready;
    logic [DW-1:0] new_centroid_in;
    logic [2:0]    cent_num;
    logic          divide_by_0;
    logic          convergence_reg_en;
    logic          convergence_regs_reset_n;
    logic          has_converged;
    logic          converge_res_available;
    logic [DW-1:0] new_centroid_out;
    logic [DW-1:0] ocr1, ocr2, ocr3, ocr4, ocr5, ocr6, ocr7, ocr8;
    logic          round_done;
    logic          converged;
    logic          algo_done;
    logic [7:0]    iter_count;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] m_regs [8];
    logic [7:0]    m_iter;
    bit            m_conv;
    bit            m_done;

    typedef struct {
        int         gap;
        bit         hc;
        logic [7:0] mi;
        logic [7:0] divm;
        bit         iws;
        int         stall_at;
        bit         poke;
        logic [7:0] exp_iter;
        bit         exp_conv;
        bit         exp_done;
    } vec_t;

    vec_t tbl [7];

    centroid_update_sequencer #(
        .dataWidth  (DW),
        .iter_width (8)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start                    (start),
        .max_iter                 (max_iter),
        .init_we                  (init_we),
        .init_addr                (init_addr),
        .init_data                (init_data),
        .mean_valid               (mean_valid),
        .mean_data                (mean_data),
        .mean_div0                (mean_div0),
        .mean_ready               (mean_ready),
        .new_centroid_in          (new_centroid_in),
        .cent_num                 (cent_num),
        .divide_by_0              (divide_by_0),
        .convergence_reg_en       (convergence_reg_en),
        .convergence_regs_reset_n (convergence_regs_reset_n),
        .has_converged            (has_converged),
        .converge_res_available   (converge_res_available),
        .new_centroid_out         (new_centroid_out),
        .old_centroid_reg_1       (ocr1),
        .old_centroid_reg_2       (ocr2),
        .old_centroid_reg_3       (ocr3),
        .old_centroid_reg_4       (ocr4),
        .old_centroid_reg_5       (ocr5),
        .old_centroid_reg_6       (ocr6),
        .old_centroid_reg_7       (ocr7),
        .old_centroid_reg_8       (ocr8),
        .round_done               (round_done),
        .converged                (converged),
        .algo_done                (algo_done),
        .iter_count               (iter_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] chk_f(input logic [DW-1:0] x, input logic d);
        return d ? ~x : x + DW'(1);
    endfunction

    // Convergence checker stand-in: one-cycle result latency.
    always @(posedge clk) begin
        if (!rst_n || !convergence_regs_reset_n) begin
            converge_res_available <= 1'b0;
        end else if (convergence_reg_en && cent_num == 3'd7) begin
            converge_res_available <= 1'b1;
        end
        if (convergence_reg_en) begin
            new_centroid_out <= chk_f(new_centroid_in, divide_by_0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] get_reg(input int i);
        case (i)
            0: return ocr1;
            1: return ocr2;
            2: return ocr3;
            3: return ocr4;
            4: return ocr5;
            5: return ocr6;
            6: return ocr7;
            default: return ocr8;
        endcase
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic check_regs(input string name);
        for (int i = 0; i < 8; i++) begin
            chk(name, 128'(get_reg(i)), 128'(m_regs[i]));
        end
    endtask

    task automatic do_round(input int gap, input bit hc, input logic [7:0] mi,
                            input logic [7:0] divm, input bit iws,
                            input int stall_at, input bit poke, input bit rst_wait);
        logic [DW-1:0] d;
        logic [DW-1:0] old;
        int            n;
        bit            seen;
        has_converged = hc;
        max_iter      = mi;
        if (m_done) begin
            m_iter = 0;
            m_conv = 0;
        end
        start = 1'b1;
        if (iws) begin
            init_we     = 1'b1;
            init_addr   = 3'd5;
            init_data   = rand_word();
            m_regs[5]   = init_data;
        end
        tick();
        start   = 1'b0;
        init_we = 1'b0;
        chk("clr_rstn", 128'(convergence_regs_reset_n), 128'(0));
        chk("clr_cent", 128'(cent_num), 128'(0));
        if (iws) chk("init_with_start", 128'(get_reg(5)), 128'(m_regs[5]));
        tick();
        chk("feed_ready", 128'(mean_ready), 128'(1));
        chk("feed_rstn", 128'(convergence_regs_reset_n), 128'(1));
        for (int k = 0; k < 8; k++) begin
            d          = rand_word();
            mean_valid = 1'b1;
            mean_data  = d;
            mean_div0  = divm[k];
            if (poke && k == 4) begin
                start     = 1'b1;
                init_we   = 1'b1;
                init_addr = 3'd0;
                init_data = ~m_regs[0];
            end
            old       = m_regs[k];
            m_regs[k] = chk_f(d, divm[k]);
            tick();
            mean_valid = 1'b0;
            start      = 1'b0;
            init_we    = 1'b0;
            chk("accept_en", 128'(convergence_reg_en), 128'(1));
            chk("accept_cent", 128'(cent_num), 128'(k));
            chk("accept_data", 128'(new_centroid_in), 128'(d));
            chk("accept_div0", 128'(divide_by_0), 128'(divm[k]));
            if (poke && k == 4) begin
                chk("poke_still_feed", 128'(mean_ready), 128'(1));
                chk("poke_reg0", 128'(get_reg(0)), 128'(m_regs[0]));
            end
            if (k < 7) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (g == 0) begin
                        chk("gap_en", 128'(convergence_reg_en), 128'(0));
                        chk("wb_not_yet", 128'(get_reg(k)), 128'(old));
                    end
                    if (g == 1) chk("wb_2cyc", 128'(get_reg(k)), 128'(m_regs[k]));
                end
            end
            if (k + 1 == stall_at) begin
                seen = 0;
                repeat (20) begin
                    tick();
                    if (cent_num != 3'(k) || convergence_reg_en || round_done) seen = 1;
                end
                chk("stall_hold", 128'(seen), 128'(0));
            end
        end
        if (rst_wait) begin
            tick();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_iter = 0;
            m_conv = 0;
            m_done = 0;
            chk("rst_rstn_low", 128'(convergence_regs_reset_n), 128'(0));
            chk("rst_ready", 128'(mean_ready), 128'(0));
            chk("rst_en", 128'(convergence_reg_en), 128'(0));
            chk("rst_cent", 128'(cent_num), 128'(0));
            chk("rst_iter", 128'(iter_count), 128'(0));
            chk("rst_algo", 128'(algo_done), 128'(0));
            check_regs("rst_regs");
            seen = 0;
            repeat (10) begin
                tick();
                if (round_done) seen = 1;
            end
            chk("rst_no_round_done", 128'(seen), 128'(0));
            chk("rst_rstn_high", 128'(convergence_regs_reset_n), 128'(1));
            chk("rst_idle", 128'(mean_ready), 128'(0));
            return;
        end
        n    = 0;
        seen = 0;
        while (!seen && n < 10) begin
            tick();
            n++;
            if (n == 1) chk("wait_cent7", 128'(cent_num), 128'(7));
            if (round_done) seen = 1;
        end
        chk("round_done_seen", 128'(seen), 128'(1));
        if (n < 3 || n > 4) begin
            n_err++;
            $display("FAIL latency: got %0d cycles expected 3..4", n);
        end
        n_chk++;
        tick();
        chk("round_done_pulse", 128'(round_done), 128'(0));
        m_iter = (m_iter == 8'hff) ? m_iter : m_iter + 8'd1;
        if (hc) begin
            m_conv = 1;
            m_done = 1;
        end else if (m_iter >= ((mi == 0) ? 8'd1 : mi)) begin
            m_conv = 0;
            m_done = 1;
        end else begin
            m_done = 0;
        end
        chk("model_iter", 128'(iter_count), 128'(m_iter));
        chk("model_conv", 128'(converged), 128'(m_conv));
        chk("model_done", 128'(algo_done), 128'(m_done));
        check_regs("model_regs");
    endtask

    initial begin
        tbl[0] = '{1, 1'b1, 8'd5, 8'h00, 1'b0, 0, 1'b0, 8'd1, 1'b1, 1'b1};
        tbl[1] = '{0, 1'b0, 8'd3, 8'h00, 1'b0, 0, 1'b0, 8'd1, 1'b0, 1'b0};
        tbl[2] = '{2, 1'b0, 8'd3, 8'h5a, 1'b1, 0, 1'b1, 8'd2, 1'b0, 1'b0};
        tbl[3] = '{0, 1'b0, 8'd3, 8'h00, 1'b0, 4, 1'b0, 8'd3, 1'b0, 1'b1};
        tbl[4] = '{2, 1'b0, 8'd0, 8'h04, 1'b0, 0, 1'b0, 8'd1, 1'b0, 1'b1};
        tbl[5] = '{0, 1'b0, 8'd2, 8'h81, 1'b0, 0, 1'b1, 8'd1, 1'b0, 1'b0};
        tbl[6] = '{3, 1'b1, 8'd2, 8'h00, 1'b1, 0, 1'b0, 8'd2, 1'b1, 1'b1};

        rst_n         = 1'b0;
        start         = 1'b0;
        max_iter      = 8'd1;
        init_we       = 1'b0;
        init_addr     = '0;
        init_data     = '0;
        mean_valid    = 1'b0;
        mean_data     = '0;
        mean_div0     = 1'b0;
        has_converged = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_iter = 0;
        m_conv = 0;
        m_done = 0;

        repeat (3) tick();
        chk("reset_rstn", 128'(convergence_regs_reset_n), 128'(0));
        chk("reset_ready", 128'(mean_ready), 128'(0));
        chk("reset_round_done", 128'(round_done), 128'(0));
        chk("reset_algo", 128'(algo_done), 128'(0));
        chk("reset_iter", 128'(iter_count), 128'(0));
        chk("reset_conv", 128'(converged), 128'(0));
        chk("reset_en", 128'(convergence_reg_en), 128'(0));
        check_regs("reset_regs");
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_reset_rstn", 128'(convergence_regs_reset_n), 128'(1));

        for (int i = 0; i < 8; i++) begin
            init_we   = 1'b1;
            init_addr = 3'(i);
            init_data = {CORD_NUM{CW'(13'h100)}};
            m_regs[i] = init_data;
            tick();
        end
        init_we = 1'b0;
        tick();
        check_regs("init_regs");

        for (int i = 0; i < 7; i++) begin
            do_round(tbl[i].gap, tbl[i].hc, tbl[i].mi, tbl[i].divm, tbl[i].iws,
                     tbl[i].stall_at, tbl[i].poke, 1'b0);
            chk("tbl_iter", 128'(iter_count), 128'(tbl[i].exp_iter));
            chk("tbl_conv", 128'(converged), 128'(tbl[i].exp_conv));
            chk("tbl_done", 128'(algo_done), 128'(tbl[i].exp_done));
        end

        for (int r = 0; r < 20; r++) begin
            do_round(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                     8'($urandom_range(0, 4)), 8'($urandom), 1'($urandom),
                     0, 1'($urandom), 1'b0);
        end

        do_round(1, 1'b0, 8'd4, 8'h00, 1'b0, 0, 1'b0, 1'b1);
        do_round(0, 1'b0, 8'd1, 8'h10, 1'b0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
